// File: rtl/pe_arr_seq.sv
// pe_arr_seq: sequencer for one matrix pass on the PE_ARR systolic array.
// Handles clear, operand feed, skew tail, drain and the completion pulse.
module pe_arr_seq #(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int KW        = 16,
    parameter int AW        = 10,
    parameter int DRAIN_CYC = 17
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic [AW-1:0]   base_addr,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            acc_clr,
    output logic            fire,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    output logic [ROWS-1:0] lane_mask_a,
    output logic [COLS-1:0] lane_mask_w
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_SKEW,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int SKEW_LEN = ROWS + COLS - 2;
    localparam int DW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int DLAST    = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

    // Where the pass goes once the skew tail is finished.
    localparam state_t POST_SKEW = (DRAIN_CYC > 0) ? S_DRAIN : S_DONE;

    state_t          state_q;
    state_t          state_n;
    logic [KW-1:0]   k_q;
    logic [AW-1:0]   addr_q;
    logic [KW:0]     s_q;
    logic [DW-1:0]   d_q;

    logic            feed_last;
    logic            skew_last;
    logic            drain_last;
    logic            step_q;
    logic            step_n;
    logic [AW-1:0]   off_v;
    logic [AW-1:0]   addr_v;
    logic [ROWS-1:0] mask_a_v;
    logic [COLS-1:0] mask_w_v;

    assign feed_last  = (s_q + (KW+1)'(1)) == {1'b0, k_q};
    assign skew_last  = ({1'b0, s_q} + (KW+2)'(1))
                        == ({2'b0, k_q} + (KW+2)'(SKEW_LEN));
    assign drain_last = d_q == DW'(DLAST);
    assign step_q     = (state_q == S_FEED) || (state_q == S_SKEW);
    assign step_n     = (state_n == S_FEED) || (state_n == S_SKEW);

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE:  if (start && !abort) state_n = S_CLEAR;
            S_CLEAR: state_n = (k_q != '0) ? S_FEED : S_DONE;
            S_FEED: begin
                if (feed_last)
                    state_n = (SKEW_LEN > 0) ? S_SKEW : POST_SKEW;
            end
            S_SKEW:  if (skew_last) state_n = POST_SKEW;
            S_DRAIN: if (drain_last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE))
            state_n = S_IDLE;
    end

    // State, command latch, step and drain counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            s_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_n;
            if ((state_q == S_IDLE) && (state_n == S_CLEAR)) begin
                k_q    <= k_len;
                addr_q <= base_addr;
            end
            s_q <= (step_q && step_n) ? s_q + (KW+1)'(1) : '0;
            d_q <= ((state_q == S_DRAIN) && (state_n == S_DRAIN))
                   ? d_q + DW'(1) : '0;
        end
    end

    // Feed address walks from base; the skew tail keeps the last one.
    always_comb begin
        off_v  = (state_q == S_FEED) ? AW'(s_q) : AW'(k_q) - AW'(1);
        addr_v = addr_q + off_v;
    end

    // Lane i is live while its skewed copy of the K-vector stream passes.
    always_comb begin
        mask_a_v = '0;
        mask_w_v = '0;
        for (int i = 0; i < ROWS; i++) begin
            mask_a_v[i] = ({1'b0, s_q} >= (KW+2)'(i))
                && ({1'b0, s_q} < ({2'b0, k_q} + (KW+2)'(i)));
        end
        for (int j = 0; j < COLS; j++) begin
            mask_w_v[j] = ({1'b0, s_q} >= (KW+2)'(j))
                && ({1'b0, s_q} < ({2'b0, k_q} + (KW+2)'(j)));
        end
    end

    // Output decode from registered state and counters only.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        acc_clr     = 1'b0;
        fire        = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        lane_mask_a = '0;
        lane_mask_w = '0;
        unique case (state_q)
            S_CLEAR: begin
                busy    = 1'b1;
                acc_clr = 1'b1;
            end
            S_FEED: begin
                busy        = 1'b1;
                fire        = 1'b1;
                rd_en       = 1'b1;
                rd_addr     = addr_v;
                lane_mask_a = mask_a_v;
                lane_mask_w = mask_w_v;
            end
            S_SKEW: begin
                busy        = 1'b1;
                fire        = 1'b1;
                rd_addr     = addr_v;
                lane_mask_a = mask_a_v;
                lane_mask_w = mask_w_v;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
